memwb_arbiter: RTL and testbench
================================

Name: memwb_arbiter

Overview:
Two-master, one-slave arbiter for the pipelined Wishbone memory bus (memwb) that feeds the NOR controller. Master 0 is the QSPI command path; master 1 is an on-chip sequencer such as a VT sweep or scrub engine. The block grants the bus per cycle-envelope (cyc), tracks in-flight requests so acks and errors go only to the owner, and bounds outstanding requests.

Parameters:
ADDRBITS, `NORADDRBITS, address width
DATABITS, `NORDATABITS, data width
MAXINFLIGHT, 16, maximum outstanding un-acked requests; power of 2, at most 128

Ports:
clk_i  in  1  system clock
reset_i  in  1  synchronous active-high reset
mN_cyc_i, mN_stb_i, mN_we_i  in  1 each (N=0,1)  master N Wishbone cycle, strobe, write enable
mN_adr_i  in  ADDRBITS  master N address
mN_dat_i  in  DATABITS  master N write data
mN_ack_o, mN_err_o, mN_stall_o  out  1 each  routed ack, err, stall for master N
mN_dat_o  out  DATABITS  read data = s_dat_i, valid when mN_ack_o
s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle, strobe, write enable
s_adr_o  out  ADDRBITS  slave address
s_dat_o  out  DATABITS  slave write data
s_ack_i, s_err_i, s_stall_i  in  1 each  slave ack, err, stall
s_dat_i  in  DATABITS  slave read data
grant_o  out  2  one-hot current owner: bit0 = m0, bit1 = m1; 00 = idle

Behaviour:
- Clock and reset: one clock, clk_i. Reset is reset_i, synchronous, active-high.
- Reset values:
  - State IDLE, last_owner = 1 (m0 wins the first tie), inflight = 0.
  - s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o = 0.
  - All mN_ack_o and mN_err_o = 0. Both mN_stall_o = 1. grant_o = 00.
- States are IDLE, GNT0 and GNT1, in a registered state register. All outputs are combinational from the state, the inflight count and the inputs.
- IDLE:
  - Only m0_cyc_i high: go to GNT0. Only m1_cyc_i high: go to GNT1.
  - Both high: grant the master != last_owner (round-robin).
  - Both mN_stall_o = 1. s_cyc_o = 0.
  - Grant latency is 1 cycle from cyc rising to s_cyc_o.
- GNTn:
  - s_cyc_o = mn_cyc_i.
  - s_stb_o = mn_stb_i & !full.
  - s_we_o, s_adr_o, s_dat_o are muxed from master n.
  - mn_stall_o = s_stall_i | full.
  - mn_ack_o = s_ack_i & (inflight != 0). mn_err_o = s_err_i.
  - The non-owner sees stall = 1, ack = 0, err = 0.
- Inflight counter, width clog2(MAXINFLIGHT)+1:
  - Increment on accept, i.e. s_stb_o & !s_stall_i.
  - Decrement on a valid ack.
  - Accept and ack in the same cycle: no change.
  - full = (inflight == MAXINFLIGHT).
  - A spurious ack (inflight = 0) is dropped, not forwarded, and the counter does not underflow.
- Release (abort semantics):
  - In GNTn, mn_cyc_i low: next state IDLE, last_owner = n, inflight cleared.
  - There is no grant hand-over without one IDLE cycle. Acks arriving in IDLE are dropped.
- Error:
  - s_err_i in GNTn is forwarded to the owner and clears inflight.
  - The state stays GNTn until the owner drops cyc.
  - s_err_i takes precedence over a same-cycle s_ack_i: no ack is forwarded.
- No preemption. A master holding cyc indefinitely starves the other, by design; the QSPI path drops cyc at CE deassertion.
- Reset mid-transaction returns everything to reset values next cycle. The slave sees cyc fall, which aborts the transaction.

Test Plan:
- Reset, then m0_cyc = 1 with 4 pipelined reads, no stall → grant_o = 01 after 1 cycle; 4 s_stb accepts; 4 m0_ack_o with data passed through; inflight returns to 0; m1_stall_o = 1 throughout.
- m0 and m1 raise cyc in the same cycle after reset → GNT0 first. m0 drops cyc → 1 IDLE cycle → GNT1. Both request again after m1 releases → GNT0 (round-robin).
- m1 issues 20 reads while the slave withholds acks → s_stb_o stops after 16 accepts; m1_stall_o = 1 while inflight = 16. One ack → exactly one more accept.
- s_ack_i with inflight = 0 in GNT0, and s_ack_i in IDLE → no mN_ack_o asserted; inflight stays 0.
- m0 has 3 in flight and drops cyc → next cycle IDLE, inflight = 0, s_cyc_o = 0; a late s_ack_i is not forwarded to either master.
- s_err_i with 2 in flight in GNT1 → m1_err_o = 1 for that cycle, inflight = 0, state remains GNT1 until m1_cyc_i falls. reset_i asserted mid-burst → all outputs at reset values next cycle.

Source files
------------

// File: rtl/memwb_arbiter_if.sv
// Pipelined Wishbone (memwb) bus bundle shared by the arbiter's master and slave sides.
`ifndef NORADDRBITS
`define NORADDRBITS 24
`endif
`ifndef NORDATABITS
`define NORDATABITS 32
`endif

interface memwb_arbiter_if #(
    parameter int unsigned ADDRBITS = `NORADDRBITS,
    parameter int unsigned DATABITS = `NORDATABITS
) ();
    logic                cyc;
    logic                stb;
    logic                we;
    logic [ADDRBITS-1:0] adr;
    logic [DATABITS-1:0] dat_w;
    logic [DATABITS-1:0] dat_r;
    logic                ack;
    logic                err;
    logic                stall;

    modport master (
        output cyc, stb, we, adr, dat_w,
        input  dat_r, ack, err, stall
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w,
        output dat_r, ack, err, stall
    );
endinterface

// File: rtl/memwb_arbiter.sv
// Two-master round-robin arbiter for the memwb bus: grants per cyc envelope,
// routes ack/err to the owner only and caps outstanding requests at MAXINFLIGHT.
`ifndef NORADDRBITS
`define NORADDRBITS 24
`endif
`ifndef NORDATABITS
`define NORDATABITS 32
`endif

module memwb_arbiter #(
    parameter int unsigned ADDRBITS    = `NORADDRBITS,
    parameter int unsigned DATABITS    = `NORDATABITS,
    parameter int unsigned MAXINFLIGHT = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    memwb_arbiter_if.slave          m0_io,
    memwb_arbiter_if.slave          m1_io,
    memwb_arbiter_if.master         s_io,
    output logic [1:0]              grant_o
);
    localparam int unsigned CNTW = $clog2(MAXINFLIGHT) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                last_owner_q, last_owner_d;
    logic [CNTW-1:0]     inflight_q, inflight_d;

    logic                own_cyc, own_stb, own_we;
    logic [ADDRBITS-1:0] own_adr;
    logic [DATABITS-1:0] own_dat;
    logic                full, accept, ack_fwd;

    logic                s_cyc_c, s_stb_c, s_we_c;
    logic [ADDRBITS-1:0] s_adr_c;
    logic [DATABITS-1:0] s_dat_c;
    logic                m0_ack_c, m0_err_c, m0_stall_c;
    logic                m1_ack_c, m1_err_c, m1_stall_c;
    logic [1:0]          grant_c;

    // Owner request mux; zero when idle so the slave bus rests at 0.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        if (state_q == GNT0) begin
            own_cyc = m0_io.cyc;
            own_stb = m0_io.stb;
            own_we  = m0_io.we;
            own_adr = m0_io.adr;
            own_dat = m0_io.dat_w;
        end else if (state_q == GNT1) begin
            own_cyc = m1_io.cyc;
            own_stb = m1_io.stb;
            own_we  = m1_io.we;
            own_adr = m1_io.adr;
            own_dat = m1_io.dat_w;
        end
    end

    assign full = (inflight_q == CNTW'(MAXINFLIGHT));

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        inflight_d   = inflight_q;
        s_cyc_c      = 1'b0;
        s_stb_c      = 1'b0;
        s_we_c       = 1'b0;
        s_adr_c      = '0;
        s_dat_c      = '0;
        m0_ack_c     = 1'b0;
        m0_err_c     = 1'b0;
        m0_stall_c   = 1'b1;
        m1_ack_c     = 1'b0;
        m1_err_c     = 1'b0;
        m1_stall_c   = 1'b1;
        grant_c      = 2'b00;
        accept       = 1'b0;
        ack_fwd      = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_io.cyc && m1_io.cyc) begin
                    state_d = last_owner_q ? GNT0 : GNT1;
                end else if (m0_io.cyc) begin
                    state_d = GNT0;
                end else if (m1_io.cyc) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                s_cyc_c = own_cyc;
                s_stb_c = own_stb & ~full;
                s_we_c  = own_we;
                s_adr_c = own_adr;
                s_dat_c = own_dat;
                accept  = s_stb_c & ~s_io.stall;
                // Error wins over a same-cycle ack; acks with nothing pending are dropped.
                ack_fwd = s_io.ack & (inflight_q != '0) & ~s_io.err;
                if (state_q == GNT0) begin
                    grant_c    = 2'b01;
                    m0_stall_c = s_io.stall | full;
                    m0_ack_c   = ack_fwd;
                    m0_err_c   = s_io.err;
                end else begin
                    grant_c    = 2'b10;
                    m1_stall_c = s_io.stall | full;
                    m1_ack_c   = ack_fwd;
                    m1_err_c   = s_io.err;
                end

                if (!own_cyc) begin
                    state_d      = IDLE;
                    last_owner_d = (state_q == GNT1);
                    inflight_d   = '0;
                end else if (s_io.err) begin
                    inflight_d = '0;
                end else if (accept && !ack_fwd) begin
                    inflight_d = inflight_q + CNTW'(1);
                end else if (!accept && ack_fwd) begin
                    inflight_d = inflight_q - CNTW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            inflight_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            inflight_q   <= inflight_d;
        end
    end

    assign s_io.cyc    = s_cyc_c;
    assign s_io.stb    = s_stb_c;
    assign s_io.we     = s_we_c;
    assign s_io.adr    = s_adr_c;
    assign s_io.dat_w  = s_dat_c;
    assign m0_io.ack   = m0_ack_c;
    assign m0_io.err   = m0_err_c;
    assign m0_io.stall = m0_stall_c;
    assign m0_io.dat_r = s_io.dat_r;
    assign m1_io.ack   = m1_ack_c;
    assign m1_io.err   = m1_err_c;
    assign m1_io.stall = m1_stall_c;
    assign m1_io.dat_r = s_io.dat_r;
    assign grant_o     = grant_c;
endmodule

// File: tb/tb_memwb_arbiter.sv
// Self-checking bench for memwb_arbiter: directed scenarios plus random traffic
// against a cycle-level behavioural model of ownership and outstanding requests.
module tb_memwb_arbiter;
    localparam int unsigned AW   = 24;
    localparam int unsigned DW   = 32;
    localparam int          MAXF = 16;
    localparam logic [10:0] RESET_VEC = 11'b00_000_001_001;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] grant;
    int         tests = 0;
    int         fails = 0;

    // Model: owner (-1 idle, 0, 1), last released owner, outstanding count.
    int mo    = -1;
    int mlast = 1;
    int mcnt  = 0;

    memwb_arbiter_if #(.ADDRBITS(AW), .DATABITS(DW)) m0_bus ();
    memwb_arbiter_if #(.ADDRBITS(AW), .DATABITS(DW)) m1_bus ();
    memwb_arbiter_if #(.ADDRBITS(AW), .DATABITS(DW)) s_bus ();

    memwb_arbiter #(.ADDRBITS(AW), .DATABITS(DW), .MAXINFLIGHT(MAXF)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .m0_io   (m0_bus.slave),
        .m1_io   (m1_bus.slave),
        .s_io    (s_bus.master),
        .grant_o (grant)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run time exceeded, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] act_vec();
        return {grant, s_bus.cyc, s_bus.stb, s_bus.we,
                m0_bus.ack, m0_bus.err, m0_bus.stall,
                m1_bus.ack, m1_bus.err, m1_bus.stall};
    endfunction

    function automatic logic [10:0] exp_vec();
        logic [1:0] g;
        logic sc, ss, sw, c, s, w, full, a, e, st;
        logic a0, e0, st0, a1, e1, st1;
        g = 2'b00; sc = 0; ss = 0; sw = 0;
        a0 = 0; e0 = 0; st0 = 1; a1 = 0; e1 = 0; st1 = 1;
        if (mo >= 0) begin
            c = (mo == 0) ? m0_bus.cyc : m1_bus.cyc;
            s = (mo == 0) ? m0_bus.stb : m1_bus.stb;
            w = (mo == 0) ? m0_bus.we  : m1_bus.we;
            full = (mcnt == MAXF);
            sc = c; ss = s && !full; sw = w;
            a  = s_bus.ack && (mcnt > 0) && !s_bus.err;
            e  = s_bus.err;
            st = s_bus.stall || full;
            if (mo == 0) begin g = 2'b01; a0 = a; e0 = e; st0 = st; end
            else         begin g = 2'b10; a1 = a; e1 = e; st1 = st; end
        end
        return {g, sc, ss, sw, a0, e0, st0, a1, e1, st1};
    endfunction

    function automatic logic [AW+DW-1:0] exp_dp();
        if (mo == 0) return {m0_bus.adr, m0_bus.dat_w};
        if (mo == 1) return {m1_bus.adr, m1_bus.dat_w};
        return '0;
    endfunction

    // Advance the model using the inputs present just before the clock edge.
    task automatic model_step();
        logic c, s, full, acc, ackv;
        if (reset) begin
            mo = -1; mlast = 1; mcnt = 0;
        end else if (mo < 0) begin
            if (m0_bus.cyc && m1_bus.cyc) mo = (mlast == 1) ? 0 : 1;
            else if (m0_bus.cyc)          mo = 0;
            else if (m1_bus.cyc)          mo = 1;
        end else begin
            c    = (mo == 0) ? m0_bus.cyc : m1_bus.cyc;
            s    = (mo == 0) ? m0_bus.stb : m1_bus.stb;
            full = (mcnt == MAXF);
            acc  = s && !full && !s_bus.stall;
            ackv = s_bus.ack && (mcnt > 0) && !s_bus.err;
            if (!c) begin
                mlast = mo; mo = -1; mcnt = 0;
            end else if (s_bus.err) begin
                mcnt = 0;
            end else begin
                mcnt = mcnt + (acc ? 1 : 0) - (ackv ? 1 : 0);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_bus.cyc = 0; m0_bus.stb = 0; m0_bus.we = 0; m0_bus.adr = '0; m0_bus.dat_w = '0;
        m1_bus.cyc = 0; m1_bus.stb = 0; m1_bus.we = 0; m1_bus.adr = '0; m1_bus.dat_w = '0;
        s_bus.ack = 0; s_bus.err = 0; s_bus.stall = 0; s_bus.dat_r = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        clear_inputs();
        m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.adr = '1; s_bus.ack = 1;
        tick();
        tick();
        #1;
        tests++;
        if (act_vec() !== RESET_VEC) begin
            fails++; $display("FAIL reset_ctrl: got %b want %b", act_vec(), RESET_VEC);
        end
        tests++;
        if (s_bus.adr !== '0 || s_bus.dat_w !== '0) begin
            fails++; $display("FAIL reset_bus: got adr %h dat %h want 0", s_bus.adr, s_bus.dat_w);
        end
        reset = 0;
        clear_inputs();
        tick();
    endtask

    task automatic test_m0_burst();
        int acc = 0;
        int acks = 0;
        logic [DW-1:0] rd;
        logic [AW-1:0] ad;
        do_reset();
        m0_bus.cyc = 1;
        #1;
        tests++;
        if (act_vec() !== exp_vec()) begin
            fails++; $display("FAIL burst_pre: got %b want %b", act_vec(), exp_vec());
        end
        tick();
        tests++;
        if (grant !== 2'b01) begin
            fails++; $display("FAIL grant_latency: got %b want 01", grant);
        end
        for (int k = 0; k < 10; k++) begin
            ad = AW'($urandom);
            rd = DW'($urandom);
            m0_bus.stb = (k < 4); m0_bus.adr = ad;
            s_bus.dat_r = rd; s_bus.ack = (k >= 2 && k < 6);
            #1;
            tests++;
            if (act_vec() !== exp_vec()) begin
                fails++; $display("FAIL burst_ctrl k=%0d: got %b want %b", k, act_vec(), exp_vec());
            end
            if (s_bus.stb) begin
                tests++;
                if (s_bus.adr !== ad) begin
                    fails++; $display("FAIL burst_adr k=%0d: got %h want %h", k, s_bus.adr, ad);
                end
            end
            if (m0_bus.ack) begin
                acks++;
                tests++;
                if (m0_bus.dat_r !== rd) begin
                    fails++; $display("FAIL burst_data k=%0d: got %h want %h", k, m0_bus.dat_r, rd);
                end
            end
            if (s_bus.stb && !s_bus.stall) acc++;
            tick();
        end
        tests++;
        if (acc != 4 || acks != 4) begin
            fails++; $display("FAIL burst_counts: got acc %0d ack %0d want 4 4", acc, acks);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_round_robin();
        int c0[10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
        int c1[10] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
        int ge[10] = '{0, 1, 1, 1, 0, 2, 2, 2, 0, 1};
        do_reset();
        for (int k = 0; k < 10; k++) begin
            m0_bus.cyc = (c0[k] != 0);
            m1_bus.cyc = (c1[k] != 0);
            #1;
            tests++;
            if (grant !== 2'(ge[k]) || act_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL rr k=%0d: got grant %b ctrl %b want grant %b ctrl %b",
                         k, grant, act_vec(), 2'(ge[k]), exp_vec());
            end
            tick();
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_inflight_limit();
        int acc = 0;
        do_reset();
        m1_bus.cyc = 1;
        tick();
        m1_bus.stb = 1;
        for (int k = 0; k < 20; k++) begin
            #1;
            tests++;
            if (act_vec() !== exp_vec()) begin
                fails++; $display("FAIL limit_ctrl k=%0d: got %b want %b", k, act_vec(), exp_vec());
            end
            if (s_bus.stb && !s_bus.stall) acc++;
            tick();
        end
        tests++;
        if (acc != 16) begin
            fails++; $display("FAIL limit_accepts: got %0d want 16", acc);
        end
        #1;
        tests++;
        if (m1_bus.stall !== 1'b1 || s_bus.stb !== 1'b0) begin
            fails++; $display("FAIL limit_full: got stall %b stb %b want 1 0", m1_bus.stall, s_bus.stb);
        end
        s_bus.ack = 1;
        #1;
        tests++;
        if (act_vec() !== exp_vec()) begin
            fails++; $display("FAIL limit_ack: got %b want %b", act_vec(), exp_vec());
        end
        tick();
        s_bus.ack = 0;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (s_bus.stb && !s_bus.stall) acc++;
            tick();
        end
        tests++;
        if (acc != 1) begin
            fails++; $display("FAIL limit_one_more: got %0d want 1", acc);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_spurious_ack();
        int acc = 0;
        do_reset();
        s_bus.ack = 1;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) m0_bus.cyc = 1;
            #1;
            tests++;
            if (m0_bus.ack !== 1'b0 || m1_bus.ack !== 1'b0) begin
                fails++; $display("FAIL spurious_ack k=%0d: got %b%b want 00", k, m1_bus.ack, m0_bus.ack);
            end
            tick();
        end
        s_bus.ack = 0;
        m0_bus.stb = 1;
        for (int k = 0; k < 18; k++) begin
            #1;
            if (s_bus.stb && !s_bus.stall) acc++;
            tick();
        end
        tests++;
        if (acc != 16) begin
            fails++; $display("FAIL no_underflow: got %0d accepts want 16", acc);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_abort();
        int acc = 0;
        do_reset();
        m0_bus.cyc = 1;
        tick();
        m0_bus.stb = 1;
        for (int k = 0; k < 3; k++) tick();
        m0_bus.stb = 0;
        m0_bus.cyc = 0;
        #1;
        tests++;
        if (act_vec() !== exp_vec()) begin
            fails++; $display("FAIL abort_release: got %b want %b", act_vec(), exp_vec());
        end
        tick();
        s_bus.ack = 1;
        #1;
        tests++;
        if (s_bus.cyc !== 1'b0 || grant !== 2'b00) begin
            fails++; $display("FAIL abort_idle: got cyc %b grant %b want 0 00", s_bus.cyc, grant);
        end
        tests++;
        if (m0_bus.ack !== 1'b0 || m1_bus.ack !== 1'b0) begin
            fails++; $display("FAIL late_ack: got %b%b want 00", m1_bus.ack, m0_bus.ack);
        end
        tick();
        s_bus.ack = 0;
        m0_bus.cyc = 1;
        tick();
        m0_bus.stb = 1;
        for (int k = 0; k < 18; k++) begin
            #1;
            if (s_bus.stb && !s_bus.stall) acc++;
            tick();
        end
        tests++;
        if (acc != 16) begin
            fails++; $display("FAIL abort_cleared: got %0d accepts want 16", acc);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_error_and_reset();
        int acc = 0;
        do_reset();
        m1_bus.cyc = 1;
        tick();
        m1_bus.stb = 1;
        for (int k = 0; k < 2; k++) tick();
        m1_bus.stb = 0;
        s_bus.err = 1;
        s_bus.ack = 1;
        #1;
        tests++;
        if (m1_bus.err !== 1'b1 || m1_bus.ack !== 1'b0 || m0_bus.err !== 1'b0) begin
            fails++; $display("FAIL err_fwd: got m1err %b m1ack %b m0err %b want 1 0 0",
                              m1_bus.err, m1_bus.ack, m0_bus.err);
        end
        tick();
        s_bus.err = 0;
        s_bus.ack = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++;
            if (grant !== 2'b10 || m1_bus.err !== 1'b0) begin
                fails++; $display("FAIL err_hold k=%0d: got grant %b err %b want 10 0", k, grant, m1_bus.err);
            end
            tick();
        end
        m1_bus.stb = 1;
        for (int k = 0; k < 18; k++) begin
            #1;
            if (s_bus.stb && !s_bus.stall) acc++;
            tick();
        end
        tests++;
        if (acc != 16) begin
            fails++; $display("FAIL err_cleared: got %0d accepts want 16", acc);
        end
        m1_bus.adr = '1;
        m1_bus.dat_w = '1;
        reset = 1;
        tick();
        #1;
        tests++;
        if (act_vec() !== RESET_VEC) begin
            fails++; $display("FAIL reset_mid: got %b want %b", act_vec(), RESET_VEC);
        end
        tests++;
        if (s_bus.adr !== '0 || s_bus.dat_w !== '0) begin
            fails++; $display("FAIL reset_mid_bus: got adr %h dat %h want 0", s_bus.adr, s_bus.dat_w);
        end
        reset = 0;
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 99) < 4) m0_bus.cyc = ~m0_bus.cyc;
            if ($urandom_range(0, 99) < 4) m1_bus.cyc = ~m1_bus.cyc;
            m0_bus.stb   = 1'($urandom_range(0, 1));
            m1_bus.stb   = 1'($urandom_range(0, 1));
            m0_bus.we    = 1'($urandom_range(0, 1));
            m1_bus.we    = 1'($urandom_range(0, 1));
            m0_bus.adr   = AW'($urandom);
            m1_bus.adr   = AW'($urandom);
            m0_bus.dat_w = DW'($urandom);
            m1_bus.dat_w = DW'($urandom);
            s_bus.stall  = ($urandom_range(0, 3) == 0);
            s_bus.ack    = ($urandom_range(0, 3) == 0);
            s_bus.err    = ($urandom_range(0, 47) == 0);
            s_bus.dat_r  = DW'($urandom);
            reset        = ($urandom_range(0, 299) == 0);
            #1;
            tests++;
            if (act_vec() !== exp_vec()) begin
                fails++; $display("FAIL rand_ctrl k=%0d: got %b want %b", k, act_vec(), exp_vec());
            end
            tests++;
            if ({s_bus.adr, s_bus.dat_w} !== exp_dp()) begin
                fails++; $display("FAIL rand_dp k=%0d: got %h want %h", k, {s_bus.adr, s_bus.dat_w}, exp_dp());
            end
            tick();
        end
        reset = 0;
        clear_inputs();
        tick();
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_m0_burst();
        test_round_robin();
        test_inflight_limit();
        test_spurious_ack();
        test_abort();
        test_error_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
